// File: rtl/mat_mult_pkg.sv
// Shared types and constants for the fixed-point matrix multiplier.
package mat_mult_pkg;

  localparam int WIDTH        = 36;  // Q19.16 signed word
  localparam int FRAC         = 16;
  localparam int N_DEF        = 6;
  localparam int MULT_LAT_DEF = 5;

  typedef logic signed [WIDTH-1:0]      word_t;
  typedef word_t [N_DEF-1:0][N_DEF-1:0] mat_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Half an output LSB, added before dropping the fraction bits (round half up).
  localparam logic [2*WIDTH-1:0] HALF_LSB =
    {{(2*WIDTH-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};

  // Full Q38.32 product back to Q19.16, rounded, wrapped to WIDTH bits.
  function automatic word_t round_q(input logic [2*WIDTH-1:0] prod);
    logic [2*WIDTH-1:0] sum;
    sum = prod + HALF_LSB;
    return word_t'(sum[FRAC+WIDTH-1:FRAC]);
  endfunction

endpackage

// File: rtl/mat_mult_array.sv
// N x N array of clock-enabled pipelined 36x36 multipliers with a rounding
// output register. No reset: validity is tracked by the controller.

// One lane: MULT_LAT product stages followed by the rounding register.
module mult_36
  import mat_mult_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEF
) (
  input  logic             clk,
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] p
);

  logic [2*WIDTH-1:0] a_x, b_x;
  logic [2*WIDTH-1:0] prod_pipe [MULT_LAT];

  // Sign-extend so the modulo-2^72 product is the exact signed product.
  assign a_x = {{WIDTH{a[WIDTH-1]}}, a};
  assign b_x = {{WIDTH{b[WIDTH-1]}}, b};

  // Product pipeline and rounding stage, all advancing only when enabled.
  always_ff @(posedge clk) begin
    if (en) begin
      prod_pipe[0] <= a_x * b_x;
      for (int s = 1; s < MULT_LAT; s++) prod_pipe[s] <= prod_pipe[s-1];
      p <= round_q(prod_pipe[MULT_LAT-1]);
    end
  end

endmodule

module mult_array
  import mat_mult_pkg::*;
#(
  parameter int n        = N_DEF,
  parameter int MULT_LAT = MULT_LAT_DEF
) (
  input  logic                           clk,
  input  logic                           en,
  input  logic [n-1:0][n-1:0][WIDTH-1:0] dataa,
  input  logic [n-1:0][n-1:0][WIDTH-1:0] datab,
  output logic [n-1:0][n-1:0][WIDTH-1:0] result
);

  for (genvar gi = 0; gi < n; gi++) begin : g_row
    for (genvar gj = 0; gj < n; gj++) begin : g_col
      mult_36 #(.MULT_LAT(MULT_LAT)) u_mul (
        .clk (clk),
        .en  (en),
        .a   (dataa[gi][gj]),
        .b   (datab[gi][gj]),
        .p   (result[gi][gj])
      );
    end
  end

endmodule

// File: rtl/mat_mult_ctrl.sv
// Controller for C = A x B: broadcasts column/row k of the latched operands
// into the multiplier array for N cycles, accumulates results as they emerge
// from the pipeline, and publishes C once the in-flight tracker drains.
module mat_mult_ctrl
  import mat_mult_pkg::*;
#(
  parameter int N        = N_DEF,
  parameter int MULT_LAT = MULT_LAT_DEF
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           start,
  input  logic                           abort,
  input  logic [N-1:0][N-1:0][WIDTH-1:0] a_in,
  input  logic [N-1:0][N-1:0][WIDTH-1:0] b_in,
  output logic                           busy,
  output logic                           done,
  output logic [N-1:0][N-1:0][WIDTH-1:0] c_out
);

  localparam int L  = MULT_LAT + 1;  // array latency incl. rounding register
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  state_t state, state_nxt;

  logic [KW-1:0] k;
  logic [L-1:0]  vld_pipe;
  logic [N-1:0][N-1:0][WIDTH-1:0] a_lat, b_lat;
  logic [N-1:0][N-1:0][WIDTH-1:0] dataa, datab, result;
  logic [N-1:0][N-1:0][WIDTH-1:0] acc, acc_nxt;

  logic issue, en, accept, kill, drained;

  assign issue   = (state == ISSUE);
  assign en      = issue || (state == DRAIN);
  assign accept  = (state == IDLE) && start;
  assign kill    = en && abort;
  // Nothing left behind the tail: after this cycle the tracker is empty.
  assign drained = ~|vld_pipe[L-2:0];
  assign busy    = en;
  assign done    = (state == DONE);

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = ISSUE;
      ISSUE: if (abort) state_nxt = IDLE;
             else if (k == KW'(N-1)) state_nxt = DRAIN;
      DRAIN: if (abort) state_nxt = IDLE;
             else if (drained) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand broadcast: every lane (i,j) sees A[i][k] and B[k][j]; zero when idle.
  always_comb begin
    dataa = '0;
    datab = '0;
    if (issue) begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          dataa[i][j] = a_lat[i][k];
          datab[i][j] = b_lat[k][j];
        end
      end
    end
  end

  // Accumulator update when the tracker tail says the array output is real.
  always_comb begin
    acc_nxt = acc;
    if (vld_pipe[L-1]) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++)
          acc_nxt[i][j] = acc[i][j] + result[i][j];
    end
  end

  // Operand latches, issue counter, valid tracker, accumulators and result.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_lat    <= '0;
      b_lat    <= '0;
      k        <= '0;
      vld_pipe <= '0;
      acc      <= '0;
      c_out    <= '0;
    end else if (accept) begin
      a_lat    <= a_in;
      b_lat    <= b_in;
      k        <= '0;
      vld_pipe <= '0;
      acc      <= '0;
    end else if (kill) begin
      // Clearing the tracker is what keeps late array outputs out of acc.
      k        <= '0;
      vld_pipe <= '0;
      acc      <= '0;
    end else begin
      if (en)    vld_pipe <= {vld_pipe[L-2:0], issue};
      if (issue) k <= k + 1'b1;
      acc <= acc_nxt;
      // Publish including the final tail's contribution.
      if ((state == DRAIN) && drained) c_out <= acc_nxt;
    end
  end

  mult_array #(.n(N), .MULT_LAT(MULT_LAT)) u_array (
    .clk    (clk),
    .en     (en),
    .dataa  (dataa),
    .datab  (datab),
    .result (result)
  );

endmodule
